// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped timer peripheral: register offsets,
// TCON bit positions and the default window base.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h4000_0000;

    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_LED     = 5'h0C;
    localparam logic [4:0] OFF_PSC     = 5'h10;
    localparam logic [4:0] OFF_SYSTICK = 5'h14;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    // The window is 32 bytes, so only the upper 27 address bits take part.
    function automatic logic in_window(input logic [26:0] addr_hi, input logic [26:0] base_hi);
        return addr_hi == base_hi;
    endfunction

endpackage

// File: rtl/mmio_timer_slave_if.sv
// MEM-stage load/store bus as seen by the timer peripheral.
interface mmio_timer_slave_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        Hit;

    modport master (output MemRead, MemWrite, Address, WrData, input RdData, Hit);
    modport slave  (input MemRead, MemWrite, Address, WrData, output RdData, Hit);
endinterface

// File: rtl/mmio_timer_slave_timer_core.sv
// Reloadable timer: TH/TL/TCON, overflow/reload and interrupt level.
// Optional prescaler built when TIMER_PRESCALE_EN is defined.
module timer_core
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_th_i,
    input  logic        we_tl_i,
    input  logic        we_tcon_i,
`ifdef TIMER_PRESCALE_EN
    input  logic        we_psc_i,
    output logic [15:0] psc_o,
`endif
    input  logic [31:0] wdata_i,
    output logic [31:0] th_o,
    output logic [31:0] tl_o,
    output logic [2:0]  tcon_o,
    output logic        irq_o
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic        irq_q, irq_d;
    logic        tick_s;
    logic        ovf_s;

`ifdef TIMER_PRESCALE_EN
    logic [15:0] psc_q, psc_d;
    logic [15:0] pcnt_q, pcnt_d;

    // Prescale divider; any TCON or PSC write restarts the count.
    always_comb begin
        psc_d = we_psc_i ? wdata_i[15:0] : psc_q;
        if (we_tcon_i || we_psc_i) begin
            pcnt_d = 16'h0000;
        end else if (tcon_q[TCON_EN]) begin
            pcnt_d = (pcnt_q == psc_q) ? 16'h0000 : pcnt_q + 16'h0001;
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    // Prescaler state.
    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q  <= 16'h0000;
            pcnt_q <= 16'h0000;
        end else begin
            psc_q  <= psc_d;
            pcnt_q <= pcnt_d;
        end
    end

    assign tick_s = tcon_q[TCON_EN] && (pcnt_q == psc_q);
    assign psc_o  = psc_q;
`else
    assign tick_s = tcon_q[TCON_EN];
`endif

    assign ovf_s = tick_s && (tl_q == 32'hFFFF_FFFF);

    // Next state: CPU write beats count/reload on TL, overflow beats status clear.
    always_comb begin
        th_d = we_th_i ? wdata_i : th_q;
        if (we_tl_i) begin
            tl_d = wdata_i;
        end else if (ovf_s) begin
            tl_d = th_q;
        end else if (tick_s) begin
            tl_d = tl_q + 32'd1;
        end else begin
            tl_d = tl_q;
        end
        tcon_d = tcon_q;
        if (we_tcon_i) begin
            tcon_d[TCON_IE:TCON_EN] = wdata_i[1:0];
        end else begin
            tcon_d[TCON_IE:TCON_EN] = tcon_q[TCON_IE:TCON_EN];
        end
        if (ovf_s) begin
            tcon_d[TCON_ST] = 1'b1;
        end else if (we_tcon_i && wdata_i[TCON_ST]) begin
            tcon_d[TCON_ST] = 1'b0;
        end else begin
            tcon_d[TCON_ST] = tcon_q[TCON_ST];
        end
        irq_d = tcon_d[TCON_IE] & tcon_d[TCON_ST];
    end

    // Timer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            th_q   <= 32'h0000_0000;
            tl_q   <= 32'h0000_0000;
            tcon_q <= 3'b000;
            irq_q  <= 1'b0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            irq_q  <= irq_d;
        end
    end

    assign th_o   = th_q;
    assign tl_o   = tl_q;
    assign tcon_o = tcon_q;
    assign irq_o  = irq_q;

endmodule

// File: rtl/mmio_timer_slave.sv
// Peripheral window: decode, registered read mux, SYSTICK, LED and the timer.
// Define TIMER_PRESCALE_EN to add the PSC register at offset 0x10.
module mmio_timer_slave
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = MMIO_BASE_DEFAULT,
    parameter int          LED_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    mmio_timer_slave_if.slave bus,
    output logic              Interrupt,
    output logic [LED_W-1:0]  LED
);

    logic             in_win_s;
    logic             wr_s;
    logic [4:0]       off_s;
    logic             we_th_s, we_tl_s, we_tcon_s;
    logic [31:0]      rd_val_s;
    logic             mapped_s;
    logic [31:0]      rd_q, rd_d;
    logic             hit_q, hit_d;
    logic [31:0]      systick_q, systick_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      th_s, tl_s;
    logic [2:0]       tcon_s;
    logic             irq_s;
    logic             unused_addr_s;
`ifdef TIMER_PRESCALE_EN
    logic             we_psc_s;
    logic [15:0]      psc_s;
`endif

    assign unused_addr_s = ^bus.Address[1:0];
    assign in_win_s      = in_window(bus.Address[31:5], BASE_ADDR[31:5]);
    assign wr_s          = bus.MemWrite & in_win_s;
    assign off_s         = {bus.Address[4:2], 2'b00};

    // Address decode, write strobes and read selection from current state.
    always_comb begin
        we_th_s   = 1'b0;
        we_tl_s   = 1'b0;
        we_tcon_s = 1'b0;
`ifdef TIMER_PRESCALE_EN
        we_psc_s  = 1'b0;
`endif
        rd_val_s  = 32'h0000_0000;
        mapped_s  = 1'b0;
        led_d     = led_q;
        case (off_s)
            OFF_TH:      begin rd_val_s = th_s;              mapped_s = 1'b1; we_th_s   = wr_s; end
            OFF_TL:      begin rd_val_s = tl_s;              mapped_s = 1'b1; we_tl_s   = wr_s; end
            OFF_TCON:    begin rd_val_s = {29'h0, tcon_s};   mapped_s = 1'b1; we_tcon_s = wr_s; end
            OFF_LED: begin
                rd_val_s = 32'(led_q);
                mapped_s = 1'b1;
                led_d    = wr_s ? bus.WrData[LED_W-1:0] : led_q;
            end
`ifdef TIMER_PRESCALE_EN
            OFF_PSC:     begin rd_val_s = {16'h0000, psc_s}; mapped_s = 1'b1; we_psc_s  = wr_s; end
`endif
            OFF_SYSTICK: begin rd_val_s = systick_q;         mapped_s = 1'b1; end
            default:     begin rd_val_s = 32'h0000_0000;     mapped_s = 1'b0; end
        endcase
        if (bus.MemRead && in_win_s && mapped_s) begin
            rd_d  = rd_val_s;
            hit_d = 1'b1;
        end else begin
            rd_d  = 32'h0000_0000;
            hit_d = 1'b0;
        end
        systick_d = systick_q + 32'd1;
    end

    // Read-return, SYSTICK and LED registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q      <= 32'h0000_0000;
            hit_q     <= 1'b0;
            systick_q <= 32'h0000_0000;
            led_q     <= {LED_W{1'b0}};
        end else begin
            rd_q      <= rd_d;
            hit_q     <= hit_d;
            systick_q <= systick_d;
            led_q     <= led_d;
        end
    end

    timer_core u_timer (
        .clk       (clk),
        .reset     (reset),
        .we_th_i   (we_th_s),
        .we_tl_i   (we_tl_s),
        .we_tcon_i (we_tcon_s),
`ifdef TIMER_PRESCALE_EN
        .we_psc_i  (we_psc_s),
        .psc_o     (psc_s),
`endif
        .wdata_i   (bus.WrData),
        .th_o      (th_s),
        .tl_o      (tl_s),
        .tcon_o    (tcon_s),
        .irq_o     (irq_s)
    );

    assign bus.RdData = rd_q;
    assign bus.Hit    = hit_q;
    assign Interrupt  = irq_s;
    assign LED        = led_q;

endmodule

// File: tb/tb_mmio_timer_slave.sv
// Scoreboard bench for mmio_timer_slave: expected read data is queued when a
// load is issued and compared against the registered response in each test.
module tb_mmio_timer_slave;
    import mmio_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic       clk = 1'b0;
    logic       reset;
    logic       Interrupt;
    logic [7:0] LED;

    mmio_timer_slave_if bus_if();

    mmio_timer_slave #(.BASE_ADDR(BASE), .LED_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .Interrupt (Interrupt),
        .LED       (LED)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_rd_q[$];
    logic        exp_hit_q[$];
    logic [31:0] obs_rd_q[$];
    logic        obs_hit_q[$];
    logic [31:0] obs_rd;
    logic        obs_hit;
    logic [31:0] e_rd, o_rd;
    logic        e_hit, o_hit;

    function automatic logic [31:0] a(input logic [4:0] off);
        return BASE + {27'h0, off};
    endfunction

    task automatic cyc(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        bus_if.MemRead  = rd;
        bus_if.MemWrite = wr;
        bus_if.Address  = addr;
        bus_if.WrData   = wd;
        @(posedge clk);
        #1;
        obs_rd  = bus_if.RdData;
        obs_hit = bus_if.Hit;
        bus_if.MemRead  = 1'b0;
        bus_if.MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input logic hit);
        exp_rd_q.push_back(exp);
        exp_hit_q.push_back(hit);
        cyc(1'b1, 1'b0, addr, 32'h0);
        obs_rd_q.push_back(obs_rd);
        obs_hit_q.push_back(obs_hit);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        cyc(1'b0, 1'b1, addr, data);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_if.RdData !== 32'h0) begin errors++; $display("FAIL reset_rddata: got %h want 00000000", bus_if.RdData); end
        checks++; if (bus_if.Hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", bus_if.Hit); end
        checks++; if (Interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", Interrupt); end
        checks++; if (LED !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want 00", LED); end
        reset = 1'b0;
    endtask

    task automatic test_systick();
        int n = 0;
        do_reset();
        rd(a(OFF_SYSTICK), 32'd0, 1'b1);
        rd(a(OFF_SYSTICK), 32'd1, 1'b1);
        wr(a(OFF_SYSTICK), 32'h0000_0000);
        cyc(1'b0, 1'b0, BASE, 32'h0);
        rd(a(OFF_SYSTICK), 32'd4, 1'b1);
        while (exp_rd_q.size() > 0) begin
            e_rd = exp_rd_q.pop_front(); e_hit = exp_hit_q.pop_front();
            o_rd = obs_rd_q.pop_front(); o_hit = obs_hit_q.pop_front();
            checks++;
            if (o_rd !== e_rd || o_hit !== e_hit) begin errors++; $display("FAIL systick rd%0d: got %h/%b want %h/%b", n, o_rd, o_hit, e_rd, e_hit); end
            n++;
        end
    endtask

    task automatic test_led_unmapped();
        int n = 0;
        do_reset();
        wr(a(OFF_LED), 32'h0000_00A5);
        checks++; if (LED !== 8'hA5) begin errors++; $display("FAIL led_out: got %h want a5", LED); end
        rd(a(OFF_LED), 32'h0000_00A5, 1'b1);
        rd(a(5'h18), 32'h0, 1'b0);
        rd(32'h5000_000C, 32'h0, 1'b0);
        exp_rd_q.push_back(32'h0000_00A5);
        exp_hit_q.push_back(1'b1);
        cyc(1'b1, 1'b1, a(OFF_LED), 32'h0000_003C);
        obs_rd_q.push_back(obs_rd);
        obs_hit_q.push_back(obs_hit);
        checks++; if (LED !== 8'h3C) begin errors++; $display("FAIL led_rw: got %h want 3c", LED); end
`ifndef TIMER_PRESCALE_EN
        rd(a(OFF_PSC), 32'h0, 1'b0);
`endif
        while (exp_rd_q.size() > 0) begin
            e_rd = exp_rd_q.pop_front(); e_hit = exp_hit_q.pop_front();
            o_rd = obs_rd_q.pop_front(); o_hit = obs_hit_q.pop_front();
            checks++;
            if (o_rd !== e_rd || o_hit !== e_hit) begin errors++; $display("FAIL led rd%0d: got %h/%b want %h/%b", n, o_rd, o_hit, e_rd, e_hit); end
            n++;
        end
    endtask

    task automatic test_overflow();
        int n = 0;
        do_reset();
        wr(a(OFF_TH), 32'hFFFF_FFFE);
        wr(a(OFF_TL), 32'hFFFF_FFFE);
        wr(a(OFF_TCON), 32'h0000_0003);
        rd(a(OFF_TL), 32'hFFFF_FFFE, 1'b1);
        rd(a(OFF_TL), 32'hFFFF_FFFF, 1'b1);
        checks++; if (Interrupt !== 1'b1) begin errors++; $display("FAIL ovf_irq_set: got %b want 1", Interrupt); end
        wr(a(OFF_TCON), 32'h0000_0007);
        checks++; if (Interrupt !== 1'b0) begin errors++; $display("FAIL ovf_irq_clear: got %b want 0", Interrupt); end
        rd(a(OFF_TCON), 32'h0000_0003, 1'b1);
        checks++; if (Interrupt !== 1'b1) begin errors++; $display("FAIL ovf_irq_again: got %b want 1", Interrupt); end
        while (exp_rd_q.size() > 0) begin
            e_rd = exp_rd_q.pop_front(); e_hit = exp_hit_q.pop_front();
            o_rd = obs_rd_q.pop_front(); o_hit = obs_hit_q.pop_front();
            checks++;
            if (o_rd !== e_rd || o_hit !== e_hit) begin errors++; $display("FAIL overflow rd%0d: got %h/%b want %h/%b", n, o_rd, o_hit, e_rd, e_hit); end
            n++;
        end
    endtask

    // Continues from test_overflow: TL was just reloaded to FFFF_FFFE.
    task automatic test_clear_race();
        int n = 0;
        rd(a(OFF_TCON), 32'h0000_0007, 1'b1);
        wr(a(OFF_TCON), 32'h0000_0007);
        checks++; if (Interrupt !== 1'b1) begin errors++; $display("FAIL race_irq: got %b want 1", Interrupt); end
        rd(a(OFF_TCON), 32'h0000_0007, 1'b1);
        rd(a(OFF_TL), 32'hFFFF_FFFF, 1'b1);
        while (exp_rd_q.size() > 0) begin
            e_rd = exp_rd_q.pop_front(); e_hit = exp_hit_q.pop_front();
            o_rd = obs_rd_q.pop_front(); o_hit = obs_hit_q.pop_front();
            checks++;
            if (o_rd !== e_rd || o_hit !== e_hit) begin errors++; $display("FAIL clear_race rd%0d: got %h/%b want %h/%b", n, o_rd, o_hit, e_rd, e_hit); end
            n++;
        end
    endtask

    task automatic test_th_reload_race();
        int n = 0;
        do_reset();
        wr(a(OFF_TH), 32'h0000_0005);
        wr(a(OFF_TL), 32'hFFFF_FFFF);
        wr(a(OFF_TCON), 32'h0000_0001);
        wr(a(OFF_TH), 32'h0000_0009);
        checks++; if (Interrupt !== 1'b0) begin errors++; $display("FAIL th_race_irq_gated: got %b want 0", Interrupt); end
        rd(a(OFF_TL), 32'h0000_0005, 1'b1);
        rd(a(OFF_TH), 32'h0000_0009, 1'b1);
        rd(a(OFF_TCON), 32'h0000_0005, 1'b1);
        while (exp_rd_q.size() > 0) begin
            e_rd = exp_rd_q.pop_front(); e_hit = exp_hit_q.pop_front();
            o_rd = obs_rd_q.pop_front(); o_hit = obs_hit_q.pop_front();
            checks++;
            if (o_rd !== e_rd || o_hit !== e_hit) begin errors++; $display("FAIL th_race rd%0d: got %h/%b want %h/%b", n, o_rd, o_hit, e_rd, e_hit); end
            n++;
        end
    endtask

    task automatic test_tl_write_race();
        int n = 0;
        do_reset();
        wr(a(OFF_TCON), 32'h0000_0001);
        wr(a(OFF_TL), 32'h0000_1000);
        rd(a(OFF_TL), 32'h0000_1000, 1'b1);
        rd(a(OFF_TL), 32'h0000_1001, 1'b1);
        while (exp_rd_q.size() > 0) begin
            e_rd = exp_rd_q.pop_front(); e_hit = exp_hit_q.pop_front();
            o_rd = obs_rd_q.pop_front(); o_hit = obs_hit_q.pop_front();
            checks++;
            if (o_rd !== e_rd || o_hit !== e_hit) begin errors++; $display("FAIL tl_race rd%0d: got %h/%b want %h/%b", n, o_rd, o_hit, e_rd, e_hit); end
            n++;
        end
    endtask

    task automatic test_reset_midcount();
        int n = 0;
        do_reset();
        wr(a(OFF_TL), 32'h0000_004E);
        wr(a(OFF_TCON), 32'h0000_0003);
        wr(a(OFF_LED), 32'h0000_00FF);
        rd(a(OFF_TL), 32'h0000_004F, 1'b1);
        reset = 1'b1;
        rd(a(OFF_TL), 32'h0, 1'b0);
        reset = 1'b0;
        checks++; if (LED !== 8'h00) begin errors++; $display("FAIL midreset_led: got %h want 00", LED); end
        checks++; if (Interrupt !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b want 0", Interrupt); end
        rd(a(OFF_TL), 32'h0, 1'b1);
        rd(a(OFF_TCON), 32'h0, 1'b1);
        while (exp_rd_q.size() > 0) begin
            e_rd = exp_rd_q.pop_front(); e_hit = exp_hit_q.pop_front();
            o_rd = obs_rd_q.pop_front(); o_hit = obs_hit_q.pop_front();
            checks++;
            if (o_rd !== e_rd || o_hit !== e_hit) begin errors++; $display("FAIL midreset rd%0d: got %h/%b want %h/%b", n, o_rd, o_hit, e_rd, e_hit); end
            n++;
        end
    endtask

`ifdef TIMER_PRESCALE_EN
    task automatic test_prescale();
        int n = 0;
        do_reset();
        wr(a(OFF_PSC), 32'h0000_0003);
        wr(a(OFF_TCON), 32'h0000_0001);
        repeat (3) cyc(1'b0, 1'b0, BASE, 32'h0);
        rd(a(OFF_TL), 32'd0, 1'b1);
        rd(a(OFF_TL), 32'd1, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, BASE, 32'h0);
        rd(a(OFF_TL), 32'd1, 1'b1);
        rd(a(OFF_TL), 32'd2, 1'b1);
        rd(a(OFF_PSC), 32'd3, 1'b1);
        while (exp_rd_q.size() > 0) begin
            e_rd = exp_rd_q.pop_front(); e_hit = exp_hit_q.pop_front();
            o_rd = obs_rd_q.pop_front(); o_hit = obs_hit_q.pop_front();
            checks++;
            if (o_rd !== e_rd || o_hit !== e_hit) begin errors++; $display("FAIL prescale rd%0d: got %h/%b want %h/%b", n, o_rd, o_hit, e_rd, e_hit); end
            n++;
        end
    endtask
`endif

    initial begin
        reset           = 1'b1;
        bus_if.MemRead  = 1'b0;
        bus_if.MemWrite = 1'b0;
        bus_if.Address  = 32'h0;
        bus_if.WrData   = 32'h0;
        test_reset();
        test_systick();
        test_led_unmapped();
        test_overflow();
        test_clear_race();
        test_th_reload_race();
        test_tl_write_race();
        test_reset_midcount();
`ifdef TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
